lpm_req_sched: RTL and testbench

- Request scheduler sitting directly upstream of the Lpm core.
- Buffers host `enter` (lookup) requests and `write` (table update) requests in separate queues.
- Issues at most one request per cycle into Lpm's enter/write methods.
- Writes have priority; a bounded-burst guard keeps lookups from starving.

---
 rtl/lpm_sched_pkg.sv | 16 +
 rtl/lpm_req_fifo.sv | 54 +++++
 rtl/lpm_req_sched.sv | 95 +++++++++
 tb/tb_lpm_req_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpm_sched_pkg.sv
// Shared types and default sizing for the Lpm request scheduler.
// Keys and write payloads are kept as packed types so queues can carry them as flat vectors.
package lpm_sched_pkg;

   typedef logic [31:0] lpm_key_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } lpm_write_t;

   localparam int DEF_ENTER_DEPTH     = 4;
   localparam int DEF_WRITE_DEPTH     = 2;
   localparam int DEF_MAX_WRITE_BURST = 3;

endpackage

// File: rtl/lpm_req_fifo.sv
// Generic ENA/RDY queue with wrap-around pointers; an entry pushed at edge N is visible at the head in cycle N+1.
// Backpressure: enq__RDY is !full from registered occupancy only, so a same-cycle pop never frees a slot early.
module lpm_req_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
)(
   input  logic             CLK,
   input  logic             nRST,
   input  logic             enq__ENA,
   input  logic [WIDTH-1:0] enq_data,
   output logic             enq__RDY,
   input  logic             deq__ENA,
   output logic [WIDTH-1:0] deq_data,
   output logic             deq__RDY
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign enq__RDY = (count != FULL_CNT);
   assign deq__RDY = (count != '0);
   assign deq_data = mem[rd_ptr];

   assign push = enq__ENA & enq__RDY;
   assign pop  = deq__ENA & deq__RDY;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (pop && !push)
            count <= count - (AW+1)'(1);
      end
   end

   // Storage needs no reset: the head is only observed while count is non-zero.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/lpm_req_sched.sv
// Queues host lookups and table writes and issues at most one per cycle to Lpm; writes win, bounded by a burst guard.
// Latency: one cycle from host accept to earliest issue; issue waits on the matching Lpm RDY, head held until granted.
module lpm_req_sched
   import lpm_sched_pkg::*;
#(
   parameter int ENTER_DEPTH     = DEF_ENTER_DEPTH,
   parameter int WRITE_DEPTH     = DEF_WRITE_DEPTH,
   parameter int MAX_WRITE_BURST = DEF_MAX_WRITE_BURST
)(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        in_enter__ENA,
   input  logic [31:0] in_enter_data,
   output logic        in_enter__RDY,
   input  logic        in_write__ENA,
   input  logic [31:0] in_write_addr,
   input  logic [31:0] in_write_data,
   output logic        in_write__RDY,
   output logic        enter__ENA,
   output logic [31:0] enter_x,
   input  logic        enter__RDY,
   output logic        write__ENA,
   output logic [31:0] write_addr,
   output logic [31:0] write_data,
   input  logic        write__RDY,
   output logic [31:0] issued_count
);

   localparam int BW = (MAX_WRITE_BURST < 1) ? 1 : $clog2(MAX_WRITE_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WRITE_BURST);

   lpm_key_t   eq_dat;
   logic       eq_vld;
   lpm_write_t wq_in;
   lpm_write_t wq_dat;
   logic       wq_vld;
   logic       e_elig;
   logic       w_elig;
   logic       grant_e;
   logic       grant_w;
   logic [BW-1:0] burst_cnt;

   assign wq_in.addr = in_write_addr;
   assign wq_in.data = in_write_data;

   lpm_req_fifo #(.WIDTH($bits(lpm_key_t)), .DEPTH(ENTER_DEPTH)) u_enter_q (
      .CLK      (CLK),
      .nRST     (nRST),
      .enq__ENA (in_enter__ENA),
      .enq_data (in_enter_data),
      .enq__RDY (in_enter__RDY),
      .deq__ENA (grant_e),
      .deq_data (eq_dat),
      .deq__RDY (eq_vld)
   );

   lpm_req_fifo #(.WIDTH($bits(lpm_write_t)), .DEPTH(WRITE_DEPTH)) u_write_q (
      .CLK      (CLK),
      .nRST     (nRST),
      .enq__ENA (in_write__ENA),
      .enq_data (wq_in),
      .enq__RDY (in_write__RDY),
      .deq__ENA (grant_w),
      .deq_data (wq_dat),
      .deq__RDY (wq_vld)
   );

   assign e_elig = eq_vld & enter__RDY;
   assign w_elig = wq_vld & write__RDY;

   // A write only yields to a waiting lookup once the burst budget is spent.
   assign grant_w = w_elig & (!e_elig | (burst_cnt < BURST_MAX));
   assign grant_e = e_elig & !grant_w;

   assign enter__ENA = grant_e;
   assign enter_x    = grant_e ? eq_dat : '0;
   assign write__ENA = grant_w;
   assign write_addr = grant_w ? wq_dat.addr : '0;
   assign write_data = grant_w ? wq_dat.data : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         burst_cnt    <= '0;
         issued_count <= '0;
      end else begin
         if (grant_w && e_elig)
            burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BW'(1);
         else
            burst_cnt <= '0;
         if (grant_e || grant_w)
            issued_count <= issued_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_lpm_req_sched.sv
// Bench for lpm_req_sched: directed vector table, hand sequences, and randomized traffic against a queue-based model.
module tb_lpm_req_sched;

   localparam int ENTER_DEPTH = 4;
   localparam int WRITE_DEPTH = 2;
   localparam int MAXB        = 3;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        in_enter_ena;
   logic [31:0] in_enter_data;
   logic        in_enter_rdy;
   logic        in_write_ena;
   logic [31:0] in_write_addr;
   logic [31:0] in_write_data;
   logic        in_write_rdy;
   logic        enter_ena;
   logic [31:0] enter_x;
   logic        enter_rdy;
   logic        write_ena;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic        write_rdy;
   logic [31:0] issued_count;

   int n_checks = 0;
   int n_errors = 0;

   lpm_req_sched #(.ENTER_DEPTH(ENTER_DEPTH), .WRITE_DEPTH(WRITE_DEPTH), .MAX_WRITE_BURST(MAXB)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .in_enter__ENA (in_enter_ena),
      .in_enter_data (in_enter_data),
      .in_enter__RDY (in_enter_rdy),
      .in_write__ENA (in_write_ena),
      .in_write_addr (in_write_addr),
      .in_write_data (in_write_data),
      .in_write__RDY (in_write_rdy),
      .enter__ENA    (enter_ena),
      .enter_x       (enter_x),
      .enter__RDY    (enter_rdy),
      .write__ENA    (write_ena),
      .write_addr    (write_addr),
      .write_data    (write_data),
      .write__RDY    (write_rdy),
      .issued_count  (issued_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          e_push; logic [31:0] e_key;
      bit          w_push; logic [31:0] w_addr; logic [31:0] w_data;
      bit          e_rdy;  bit w_rdy;
      bit          x_ie_rdy; bit x_iw_rdy;
      bit          x_e_ena; logic [31:0] x_e_x;
      bit          x_w_ena; logic [31:0] x_w_addr; logic [31:0] x_w_data;
      logic [31:0] x_cnt;
   } vec_t;

   vec_t vecs [14];

   // Reference model: plain queues and counters following the scheduling rules.
   logic [31:0] mq_e [$];
   logic [63:0] mq_w [$];
   int          m_burst;
   logic [31:0] m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq_e.delete();
      mq_w.delete();
      m_burst = 0;
      m_cnt   = '0;
   endtask

   task automatic drive(input bit ep, input logic [31:0] ek, input bit wp,
                        input logic [31:0] wa, input logic [31:0] wd, input bit er, input bit wr);
      in_enter_ena  = ep;
      in_enter_data = ek;
      in_write_ena  = wp;
      in_write_addr = wa;
      in_write_data = wd;
      enter_rdy     = er;
      write_rdy     = wr;
   endtask

   // Called at posedge+1; checks at the falling edge, then advances one cycle.
   task automatic step(input bit ep, input logic [31:0] ek, input bit wp,
                       input logic [31:0] wa, input logic [31:0] wd, input bit er, input bit wr);
      bit e_el, w_el, gw, ge;
      logic [63:0] wh;
      drive(ep, ek, wp, wa, wd, er, wr);
      #4;
      e_el = (mq_e.size() > 0) && er;
      w_el = (mq_w.size() > 0) && wr;
      gw   = w_el && (!e_el || (m_burst < MAXB));
      ge   = e_el && !gw;
      wh   = gw ? mq_w[0] : 64'd0;
      chk("in_enter_rdy", in_enter_rdy, mq_e.size() < ENTER_DEPTH);
      chk("in_write_rdy", in_write_rdy, mq_w.size() < WRITE_DEPTH);
      chk("enter_ena", enter_ena, ge);
      chk("enter_x", enter_x, ge ? mq_e[0] : 32'd0);
      chk("write_ena", write_ena, gw);
      chk("write_addr", write_addr, wh[63:32]);
      chk("write_data", write_data, wh[31:0]);
      chk("one_grant", enter_ena & write_ena, 1'b0);
      chk("issued_count", issued_count, m_cnt);
      if (gw) begin
         m_burst = e_el ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
         void'(mq_w.pop_front());
      end else begin
         m_burst = 0;
      end
      if (ge) void'(mq_e.pop_front());
      if (gw || ge) m_cnt = m_cnt + 32'd1;
      if (ep) mq_e.push_back(ek);
      if (wp) mq_w.push_back({wa, wd});
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_clear();
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   function automatic vec_t mk(bit ep, logic [31:0] ek, bit wp, int wk, bit er, bit wr,
                               bit xie, bit xiw, bit xe, logic [31:0] xx, bit xw, int xwk, int xc);
      vec_t v;
      v.e_push = ep; v.e_key = ek;
      v.w_push = wp; v.w_addr = wp ? 32'h100 + wk : 0; v.w_data = wp ? 32'hD000_0000 + wk : 0;
      v.e_rdy = er; v.w_rdy = wr;
      v.x_ie_rdy = xie; v.x_iw_rdy = xiw;
      v.x_e_ena = xe; v.x_e_x = xx;
      v.x_w_ena = xw;
      v.x_w_addr = xw ? 32'h100 + xwk : 0;
      v.x_w_data = xw ? 32'hD000_0000 + xwk : 0;
      v.x_cnt = xc;
      return v;
   endfunction

   initial begin
      nRST = 1'b0;
      drive(0, 0, 0, 0, 0, 1, 1);
      #2;
      chk("rst_enter_ena", enter_ena, 0);
      chk("rst_write_ena", write_ena, 0);
      chk("rst_count", issued_count, 0);
      chk("rst_enter_x", enter_x, 0);
      chk("rst_write_addr", write_addr, 0);
      do_reset();

      // Single lookup latency, then W,W,W,E,W,W,W burst pattern with write refills.
      vecs[0]  = mk(0, 0,            0, 0, 1, 1, 1, 1, 0, 0,            0, 0, 0);
      vecs[1]  = mk(1, 32'h0A0B0C0D, 0, 0, 1, 1, 1, 1, 0, 0,            0, 0, 0);
      vecs[2]  = mk(0, 0,            0, 0, 1, 1, 1, 1, 1, 32'h0A0B0C0D, 0, 0, 0);
      vecs[3]  = mk(0, 0,            0, 0, 0, 0, 1, 1, 0, 0,            0, 0, 1);
      vecs[4]  = mk(1, 32'hE1,       1, 1, 0, 0, 1, 1, 0, 0,            0, 0, 1);
      vecs[5]  = mk(0, 0,            1, 2, 0, 0, 1, 1, 0, 0,            0, 0, 1);
      vecs[6]  = mk(0, 0,            0, 0, 1, 1, 1, 0, 0, 0,            1, 1, 1);
      vecs[7]  = mk(0, 0,            1, 3, 1, 1, 1, 1, 0, 0,            1, 2, 2);
      vecs[8]  = mk(0, 0,            1, 4, 1, 1, 1, 1, 0, 0,            1, 3, 3);
      vecs[9]  = mk(0, 0,            1, 5, 1, 1, 1, 1, 1, 32'hE1,       0, 0, 4);
      vecs[10] = mk(0, 0,            0, 0, 1, 1, 1, 0, 0, 0,            1, 4, 5);
      vecs[11] = mk(0, 0,            1, 6, 1, 1, 1, 1, 0, 0,            1, 5, 6);
      vecs[12] = mk(0, 0,            0, 0, 1, 1, 1, 1, 0, 0,            1, 6, 7);
      vecs[13] = mk(0, 0,            0, 0, 1, 1, 1, 1, 0, 0,            0, 0, 8);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].e_push, vecs[i].e_key, vecs[i].w_push, vecs[i].w_addr, vecs[i].w_data,
               vecs[i].e_rdy, vecs[i].w_rdy);
         #4;
         chk($sformatf("v%0d_in_enter_rdy", i), in_enter_rdy, vecs[i].x_ie_rdy);
         chk($sformatf("v%0d_in_write_rdy", i), in_write_rdy, vecs[i].x_iw_rdy);
         chk($sformatf("v%0d_enter_ena", i), enter_ena, vecs[i].x_e_ena);
         chk($sformatf("v%0d_enter_x", i), enter_x, vecs[i].x_e_x);
         chk($sformatf("v%0d_write_ena", i), write_ena, vecs[i].x_w_ena);
         chk($sformatf("v%0d_write_addr", i), write_addr, vecs[i].x_w_addr);
         chk($sformatf("v%0d_write_data", i), write_data, vecs[i].x_w_data);
         chk($sformatf("v%0d_count", i), issued_count, vecs[i].x_cnt);
         @(posedge CLK);
         #1;
      end

      // Fill the enter queue while Lpm is blocked, then drain in order.
      do_reset();
      for (int i = 0; i < ENTER_DEPTH; i++)
         step(1, 32'hC0DE_0000 + i, 0, 0, 0, 0, 0);
      chk("fill_full", in_enter_rdy, 1'b0);
      for (int i = 0; i < ENTER_DEPTH + 1; i++)
         step(0, 0, 0, 0, 0, 1, 0);
      chk("drain_count", issued_count, ENTER_DEPTH);

      // Blocked write must not stall a ready lookup.
      do_reset();
      step(1, 32'h1234, 1, 32'hAA, 32'hBB, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("blocked_write_count", issued_count, 2);

      // Reset in the middle of a burst discards queued work.
      do_reset();
      step(1, 32'h51, 1, 32'h61, 32'h71, 0, 0);
      step(1, 32'h52, 1, 32'h62, 32'h72, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0, 1, 1);
      #2;
      nRST = 1'b0;
      #1;
      chk("arst_enter_ena", enter_ena, 0);
      chk("arst_write_ena", write_ena, 0);
      chk("arst_count", issued_count, 0);
      model_clear();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, 0, 1, 1);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         bit ep, wp, er, wr;
         ep = ($urandom_range(0, 1) == 1) && (mq_e.size() < ENTER_DEPTH);
         wp = ($urandom_range(0, 2) != 0) && (mq_w.size() < WRITE_DEPTH);
         er = $urandom_range(0, 9) < 7;
         wr = $urandom_range(0, 9) < 6;
         step(ep, $urandom, wp, $urandom, $urandom, er, wr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
